// File: rtl/btn_pkg.sv
// Shared types and default timing for the button gesture decoder.
// Defaults assume a 50 MHz clock: 400 ms long press, 100 ms double-click gap, 50 ms repeat.
package btn_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRESS1,
    GAP,
    PRESS2,
    LONG
  } btn_state_e;

  localparam int unsigned DEF_LONG_CYCLES    = 20_000_000;
  localparam int unsigned DEF_DBL_GAP_CYCLES = 5_000_000;
  localparam int unsigned DEF_REPEAT_CYCLES  = 2_500_000;
  localparam int unsigned DEF_CNT_W          = 26;

endpackage

// File: rtl/btn_edge.sv
// Edge detector for a debounced active-low input: press/release strobes and held level.
module btn_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n,
  output logic held,
  output logic press_c,
  output logic release_c
);

  logic btn_q;
  logic armed;

  // The first sample after reset only sets the baseline, so a button held through reset is not a press
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_q <= 1'b1;
      armed <= 1'b0;
      held  <= 1'b0;
    end else begin
      btn_q <= btn_n;
      armed <= 1'b1;
      held  <= ~btn_n;
    end
  end

  assign press_c   = armed & btn_q & ~btn_n;
  assign release_c = armed & ~btn_q & btn_n;

endmodule

// File: rtl/btn_event.sv
// Button gesture decoder: turns a debounced active-low level into press, release,
// click, double-click, long-press and auto-repeat single-cycle pulses.
module btn_event
  import btn_pkg::*;
#(
  parameter int unsigned LONG_CYCLES    = DEF_LONG_CYCLES,
  parameter int unsigned DBL_GAP_CYCLES = DEF_DBL_GAP_CYCLES,
  parameter int unsigned REPEAT_CYCLES  = DEF_REPEAT_CYCLES,
  parameter int unsigned CNT_W          = DEF_CNT_W
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n,
  input  logic en,
  output logic held,
  output logic press_pulse,
  output logic release_pulse,
  output logic click,
  output logic dbl_click,
  output logic long_press,
  output logic repeat_pulse
);

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(DBL_GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);
  localparam bit               REP_EN    = (REPEAT_CYCLES != 0);

  btn_state_e       state;
  logic [CNT_W-1:0] cnt;
  logic             press_c;
  logic             release_c;

  btn_edge u_edge (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn_n    (btn_n),
    .held     (held),
    .press_c  (press_c),
    .release_c(release_c)
  );

  // Gesture FSM with one shared saturating counter, cleared on every state change
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      click         <= 1'b0;
      dbl_click     <= 1'b0;
      long_press    <= 1'b0;
      repeat_pulse  <= 1'b0;
    end else begin
      press_pulse   <= en & press_c;
      release_pulse <= en & release_c;
      click         <= 1'b0;
      dbl_click     <= 1'b0;
      long_press    <= 1'b0;
      repeat_pulse  <= 1'b0;
      if (cnt != CNT_MAX) cnt <= cnt + CNT_W'(1);

      if (!en) begin
        state <= IDLE;
        cnt   <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            if (press_c) begin
              state <= PRESS1;
              cnt   <= '0;
            end
          end
          PRESS1: begin
            if (release_c) begin
              state <= GAP;
              cnt   <= '0;
            end else if (!btn_n && cnt == LONG_LAST) begin
              state      <= LONG;
              cnt        <= '0;
              long_press <= 1'b1;
            end
          end
          GAP: begin
            // A re-press on the timeout cycle still counts as the second press
            if (press_c) begin
              state <= PRESS2;
              cnt   <= '0;
            end else if (cnt == GAP_LAST) begin
              state <= IDLE;
              cnt   <= '0;
              click <= 1'b1;
            end
          end
          PRESS2: begin
            if (release_c) begin
              state     <= IDLE;
              cnt       <= '0;
              dbl_click <= 1'b1;
            end else if (!btn_n && cnt == LONG_LAST) begin
              state      <= LONG;
              cnt        <= '0;
              click      <= 1'b1;
              long_press <= 1'b1;
            end
          end
          LONG: begin
            if (release_c) begin
              state <= IDLE;
              cnt   <= '0;
            end else if (REP_EN && cnt == REP_LAST) begin
              cnt          <= '0;
              repeat_pulse <= 1'b1;
            end
          end
          default: begin
            state <= IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

endmodule
